// File: rtl/my_fifo_pkg.sv
// my_fifo_pkg: shared default geometry and flag thresholds for the my_fifo block.
package my_fifo_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_AF_LEVEL = 14;
    localparam int DEF_AE_LEVEL = 2;
    localparam int PTR_W        = $clog2(DEF_DEPTH);
endpackage

// File: rtl/my_fifo_mem.sv
// my_fifo_mem: DEPTH x DATA_W register array, one write port, one registered read port.
// Storage is deliberately left unreset; only the read register clears.
module my_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/my_fifo.sv
// my_fifo: single-clock FIFO, one operation per cycle selected by W and gated by EN.
// Full/empty come from the occupancy count, so pointer equality is never ambiguous.
module my_fifo
    import my_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEF_AF_LEVEL,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    input  logic              CLK,
    input  logic              W,
    input  logic              EN,
    output logic              AF,
    output logic              AE,
    output logic              F,
    output logic              E,
    input  logic              RST
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          wr, rd;

    assign wr = EN & W & ~F;
    assign rd = EN & ~W & ~E;

    always_comb begin
        wr_ptr_d = wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = wr ? count_q + (PW+1)'(1) : rd ? count_q - (PW+1)'(1) : count_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign F  = count_q == (PW+1)'(DEPTH);
    assign E  = count_q == '0;
    assign AF = count_q >= (PW+1)'(AF_LEVEL);
    assign AE = count_q <= (PW+1)'(AE_LEVEL);

    my_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(PW)) u_mem (
        .clk_i   (CLK),
        .rst_i   (RST),
        .we_i    (wr),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_i),
        .re_i    (rd),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_o)
    );
endmodule

// File: tb/tb_my_fifo.sv
// tb_my_fifo: directed and random stimulus against a queue-based reference FIFO.
module tb_my_fifo;
    logic [31:0] data_i, data_o;
    logic CLK, W, EN, AF, AE, F, E, RST;

    int tests = 0;
    int fails = 0;
    logic [31:0] q[$];
    logic [31:0] exp_do = '0;

    my_fifo dut (
        .data_i (data_i), .data_o (data_o), .CLK (CLK), .W (W), .EN (EN),
        .AF (AF), .AE (AE), .F (F), .E (E), .RST (RST)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        int n = q.size();
        chk({tag, " flags"}, {28'd0, F, AF, AE, E},
            {28'd0, n == 16, n >= 14, n <= 2, n == 0});
        chk({tag, " data_o"}, data_o, exp_do);
    endtask

    task automatic step(input logic en, input logic w, input logic [31:0] d, input string tag);
        @(negedge CLK);
        EN = en; W = w; data_i = d;
        @(posedge CLK);
        if (en && w && q.size() < 16) q.push_back(d);
        else if (en && !w && q.size() > 0) exp_do = q.pop_front();
        #1 chk_all(tag);
    endtask

    initial begin
        RST = 1; EN = 0; W = 0; data_i = '0;
        #2 chk_all("reset");
        @(negedge CLK) RST = 0;
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, "idle_read");
        for (int i = 1; i <= 18; i++) step(1, 1, 32'(i), "fill");
        chk("fill_count", 32'(q.size()), 32'd16);
        for (int i = 1; i <= 18; i++) step(1, 0, 32'h0, "drain");
        chk("drain_last", data_o, 32'd16);
        for (int i = 0; i < 10; i++) step(1, 1, $urandom, "wrap_w10");
        for (int i = 0; i < 10; i++) step(1, 0, 32'h0, "wrap_r10");
        for (int i = 0; i < 12; i++) step(1, 1, 32'hA0 + 32'(i), "wrap_w12");
        for (int i = 0; i < 12; i++) step(1, 0, 32'h0, "wrap_r12");
        chk("wrap_end", data_o, 32'hAB);
        for (int i = 0; i < 5; i++) step(1, 1, 32'h50 + 32'(i), "gate_fill");
        for (int i = 0; i < 4; i++) step(0, 1'(i), $urandom, "gate_idle");
        step(1, 0, 32'h0, "gate_read");
        chk("gate_oldest", data_o, 32'h50);
        for (int i = 0; i < 8; i++) step(1, 1, $urandom, "pre_reset");
        @(negedge CLK);
        EN = 0;
        #1 RST = 1;
        q.delete();
        exp_do = '0;
        #1 chk_all("async_reset");
        @(negedge CLK) RST = 0;
        step(1, 0, 32'h0, "read_after_reset");
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom, "random");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
